alu_lhs_shift_sequencer: RTL and testbench
==========================================

// Module: alu_lhs_shift_sequencer
// PURPOSE
//  Initiator side of the ALU LHS shift unit. Accepts one multi-bit shift/rotate request.
//  Issues N single-bit shift operations to the LHS unit over its control interface:
//  AC4_LHS0/AC5_LHS1, LCarryIn, LHS in; Shift, LCarryOut back.
//  Feeds each registered result back as the next operand, then returns the final byte
//  and carry. Sits in the ALU control path beside the LHS unit and shares AluClock with it.
// PARAMETERS
//  CNT_W  3  shift-count width; max steps per request = 2**CNT_W-1
// PORTS
//  AluClock   in   1      ALU clock; all state changes on posedge
//  Reset      in   1      synchronous, active-high reset
//  Start      in   1      request strobe; sampled only in IDLE
//  Dir        in   1      0 = shift left, 1 = shift right
//  Mode       in   2      00 logical, 01 rotate-through-carry, 10 rotate, 11 arithmetic
//  Count      in   CNT_W  number of single-bit steps
//  Operand    in   8      initial byte
//  CarryIn    in   1      initial carry (used by Mode 01; returned unchanged when Count=0)
//  LHS        out  8      operand presented to the LHS unit
//  AC4_LHS0   out  1      LHS unit select bit 0
//  AC5_LHS1   out  1      LHS unit select bit 1
//  LCarryIn   out  1      carry presented to the LHS unit
//  Shift      in   8      registered result from the LHS unit
//  LCarryOut  in   1      registered carry from the LHS unit
//  Busy       out  1      high in every state except IDLE
//  Done       out  1      one-cycle pulse when Result/CarryOut become valid
//  Result     out  8      final byte; held until the next accepted Start
//  CarryOut   out  1      final carry; held until the next accepted Start
// BEHAVIOUR
//  - Reset: state=IDLE; work=0, carry=0, cnt=0.
//    Outputs after reset: LHS=0, AC4_LHS0=0, AC5_LHS1=0, LCarryIn=0, Busy=0, Done=0,
//    Result=0, CarryOut=0. Reset wins over every other input in any state.
//  - LHS unit contract: select {AC5,AC4} = 00 pass, 01 left, 10 right, 11 zero.
//    Shift/LCarryOut are valid the cycle after the selects and LHS are driven.
//  - States: IDLE -> ISSUE <-> CAPTURE -> DONE -> IDLE.
//  - IDLE: on Start, load work=Operand, carry=CarryIn, cnt=Count.
//    Next state is ISSUE if Count!=0, else DONE. Start in any other state is ignored.
//  - ISSUE (one cycle): LHS=work; {AC5,AC4}=Dir?10:01.
//    LCarryIn by Mode:
//      00: 0
//      01: carry
//      10: Dir?work[0]:work[7]
//      11: Dir?work[7]:0 (left arithmetic = logical left)
//    Next state CAPTURE.
//  - CAPTURE (one cycle): selects=00, LHS=work.
//    At posedge: work<=Shift, carry<=LCarryOut, cnt<=cnt-1.
//    Next state DONE if cnt==1, else ISSUE.
//  - DONE (one cycle): Done=1, Result<=work, CarryOut<=carry, then IDLE.
//    Result/CarryOut are visible from the DONE cycle onward.
//  - Outside ISSUE, {AC5,AC4}=00 and LCarryIn=0. Select 11 (zero) is never issued.
//  - Latency: with Start sampled at cycle 0, Done is high in cycle 2N+1.
//    Count=0 gives Done in cycle 1, with Result=Operand and CarryOut=CarryIn.
//  - Back-to-back: a Start in the cycle after DONE (IDLE) is accepted; the minimum
//    request period is 2N+2 cycles.
//  - cnt never wraps: it is decremented only in CAPTURE, where cnt>=1 always holds.
//  - Reset mid-operation aborts the request: no Done pulse; Result/CarryOut are cleared to 0.
// TESTING
//  - Logical left, Operand=0x81, Count=3 -> steps 0x02/1, 0x04/0, 0x08/0;
//    Result=0x08, CarryOut=0, Done in cycle 7.
//  - Rotate right, Operand=0x01, Count=1 -> LCarryIn=1 during ISSUE;
//    Result=0x80, CarryOut=1, Done in cycle 3.
//  - RCL, Dir=0, Mode=01, Operand=0x80, CarryIn=0, Count=2 -> 0x00/1, then 0x01/0;
//    Result=0x01, CarryOut=0.
//  - Arithmetic right, Operand=0x90, Count=4 -> 0xC8, 0xE4, 0xF2, 0xF9;
//    Result=0xF9, CarryOut=0, Done in cycle 9.
//  - Count=0, Operand=0x5A, CarryIn=1 -> selects stay 00; Done in cycle 1;
//    Result=0x5A, CarryOut=1.
//  - Start pulsed while Busy is ignored; Reset asserted in CAPTURE -> next cycle IDLE,
//    all outputs 0, no Done pulse.

Source files
------------

// File: rtl/alu_lhs_shift_sequencer_if.sv
// Request/response and LHS-unit control bundle for the multi-bit shift sequencer.
interface alu_lhs_shift_sequencer_if #(
    parameter int unsigned CNT_W = 3
);
    logic             start;
    logic             dir;
    logic [1:0]       mode;
    logic [CNT_W-1:0] count;
    logic [7:0]       operand;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [7:0]       result;
    logic             carry_out;

    logic [7:0]       lhs;
    logic             ac4_lhs0;
    logic             ac5_lhs1;
    logic             lcarry_in;
    logic [7:0]       shift;
    logic             lcarry_out;

    // Requester plus LHS unit side.
    modport master (
        output start, dir, mode, count, operand, carry_in, shift, lcarry_out,
        input  busy, done, result, carry_out, lhs, ac4_lhs0, ac5_lhs1, lcarry_in
    );

    // Sequencer side.
    modport slave (
        input  start, dir, mode, count, operand, carry_in, shift, lcarry_out,
        output busy, done, result, carry_out, lhs, ac4_lhs0, ac5_lhs1, lcarry_in
    );
endinterface

// File: rtl/alu_lhs_shift_sequencer.sv
// Breaks one multi-bit shift/rotate request into single-bit LHS unit operations,
// feeding each registered result back as the next operand.
module alu_lhs_shift_sequencer #(
    parameter int unsigned CNT_W = 3
) (
    input logic                          AluClock,
    input logic                          Reset,
    alu_lhs_shift_sequencer_if.slave     bus
);
    typedef enum logic [1:0] {StIdle, StIssue, StCapture, StDone} state_t;

    state_t           state_q;
    logic [7:0]       work_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic [1:0]       mode_q;
    logic [1:0]       sel_q;
    logic             lcin_q;
    logic             done_q;
    logic [7:0]       result_q;
    logic             carry_out_q;

    // Operand/carry that the next ISSUE cycle will present, used to precompute its carry-in.
    logic [7:0] nxt_work;
    logic       nxt_carry;
    logic       nxt_dir;
    logic [1:0] nxt_mode;
    logic       nxt_lcin;

    always_comb begin
        nxt_work  = bus.shift;
        nxt_carry = bus.lcarry_out;
        nxt_dir   = dir_q;
        nxt_mode  = mode_q;
        if (state_q == StIdle) begin
            nxt_work  = bus.operand;
            nxt_carry = bus.carry_in;
            nxt_dir   = bus.dir;
            nxt_mode  = bus.mode;
        end
        case (nxt_mode)
            2'b01:   nxt_lcin = nxt_carry;
            2'b10:   nxt_lcin = nxt_dir ? nxt_work[0] : nxt_work[7];
            2'b11:   nxt_lcin = nxt_dir ? nxt_work[7] : 1'b0;
            default: nxt_lcin = 1'b0;
        endcase
    end

    always_ff @(posedge AluClock) begin
        if (Reset) begin
            state_q     <= StIdle;
            work_q      <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            mode_q      <= 2'b00;
            sel_q       <= 2'b00;
            lcin_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            sel_q  <= 2'b00;
            lcin_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        work_q  <= bus.operand;
                        carry_q <= bus.carry_in;
                        cnt_q   <= bus.count;
                        dir_q   <= bus.dir;
                        mode_q  <= bus.mode;
                        if (bus.count != '0) begin
                            state_q <= StIssue;
                            sel_q   <= bus.dir ? 2'b10 : 2'b01;
                            lcin_q  <= nxt_lcin;
                        end else begin
                            state_q     <= StDone;
                            done_q      <= 1'b1;
                            result_q    <= bus.operand;
                            carry_out_q <= bus.carry_in;
                        end
                    end
                end
                StIssue: state_q <= StCapture;
                StCapture: begin
                    work_q  <= bus.shift;
                    carry_q <= bus.lcarry_out;
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= StDone;
                        done_q      <= 1'b1;
                        result_q    <= bus.shift;
                        carry_out_q <= bus.lcarry_out;
                    end else begin
                        state_q <= StIssue;
                        sel_q   <= dir_q ? 2'b10 : 2'b01;
                        lcin_q  <= nxt_lcin;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.lhs       = work_q;
    assign bus.ac4_lhs0  = sel_q[0];
    assign bus.ac5_lhs1  = sel_q[1];
    assign bus.lcarry_in = lcin_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;

    logic unused_carry;
    assign unused_carry = carry_q;
endmodule

// File: tb/tb_alu_lhs_shift_sequencer.sv
// Directed bench for the LHS shift sequencer with a behavioural LHS unit attached.
module tb_alu_lhs_shift_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_lhs_shift_sequencer_if #(.CNT_W(3)) bus ();
    alu_lhs_shift_sequencer #(.CNT_W(3)) dut (
        .AluClock (clk),
        .Reset    (rst),
        .bus      (bus)
    );

    // LHS unit: registered result one cycle after selects; 00 pass, 01 left, 10 right, 11 zero.
    always @(posedge clk) begin
        if (rst) begin
            bus.shift      <= 8'h00;
            bus.lcarry_out <= 1'b0;
        end else begin
            case ({bus.ac5_lhs1, bus.ac4_lhs0})
                2'b01: begin
                    bus.shift      <= {bus.lhs[6:0], bus.lcarry_in};
                    bus.lcarry_out <= bus.lhs[7];
                end
                2'b10: begin
                    bus.shift      <= {bus.lcarry_in, bus.lhs[7:1]};
                    bus.lcarry_out <= bus.lhs[0];
                end
                2'b11: begin
                    bus.shift      <= 8'h00;
                    bus.lcarry_out <= 1'b0;
                end
                default: begin
                    bus.shift      <= bus.lhs;
                    bus.lcarry_out <= 1'b0;
                end
            endcase
        end
    end

    int checks = 0;
    int errors = 0;
    logic first_lcin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // steps/scarry hold expected per-step byte/carry, first step in the MSBs.
    task automatic do_req(input string tag, input bit d, input bit [1:0] m, input bit [2:0] n,
                          input bit [7:0] op, input bit ci, input bit [31:0] steps,
                          input bit [3:0] scarry, input bit [7:0] er, input bit ec,
                          input bit poke);
        int cyc;
        int issues;
        int k;
        bit bad_sel;
        bit prev_issue;
        logic [1:0] sel;
        bus.dir      = d;
        bus.mode     = m;
        bus.count    = n;
        bus.operand  = op;
        bus.carry_in = ci;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1; issues = 0; k = 0; bad_sel = 0; prev_issue = 0; first_lcin = 1'bx;
        chk($sformatf("%s/busy_run", tag), bus.busy, 1);
        while (!bus.done && cyc < 40) begin
            sel = {bus.ac5_lhs1, bus.ac4_lhs0};
            if (sel != 2'b00) begin
                issues++;
                if (issues == 1) first_lcin = bus.lcarry_in;
                if (sel != (d ? 2'b10 : 2'b01)) bad_sel = 1;
            end else if (prev_issue && k < 4) begin
                chk($sformatf("%s/step%0d", tag, k), bus.shift, steps[31-8*k -: 8]);
                chk($sformatf("%s/stepc%0d", tag, k), bus.lcarry_out, scarry[3-k]);
                k++;
            end
            prev_issue = (sel != 2'b00);
            if (poke && cyc == 3) begin
                bus.start   = 1'b1;
                bus.operand = 8'hFF;
                bus.count   = 3'd1;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            cyc++;
        end
        chk($sformatf("%s/done_cycle", tag), cyc, 2 * n + 1);
        chk($sformatf("%s/result", tag), bus.result, er);
        chk($sformatf("%s/carry_out", tag), bus.carry_out, ec);
        chk($sformatf("%s/issues", tag), issues, n);
        chk($sformatf("%s/bad_sel", tag), bad_sel, 0);
        chk($sformatf("%s/sel_done", tag), {bus.ac5_lhs1, bus.ac4_lhs0}, 0);
        @(posedge clk); #1;
        chk($sformatf("%s/done_pulse", tag), bus.done, 0);
        chk($sformatf("%s/idle", tag), bus.busy, 0);
        chk($sformatf("%s/held", tag), {bus.carry_out, bus.result}, {ec, er});
    endtask

    task automatic chk_zero(input string tag);
        chk($sformatf("%s/lhs", tag), bus.lhs, 0);
        chk($sformatf("%s/sel", tag), {bus.ac5_lhs1, bus.ac4_lhs0}, 0);
        chk($sformatf("%s/lcin", tag), bus.lcarry_in, 0);
        chk($sformatf("%s/busy", tag), bus.busy, 0);
        chk($sformatf("%s/done", tag), bus.done, 0);
        chk($sformatf("%s/result", tag), bus.result, 0);
        chk($sformatf("%s/carry_out", tag), bus.carry_out, 0);
    endtask

    initial begin
        int pulses;
        rst = 1'b1;
        bus.start = 1'b0; bus.dir = 1'b0; bus.mode = 2'b00; bus.count = 3'd0;
        bus.operand = 8'h00; bus.carry_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        do_req("lsl", 1'b0, 2'b00, 3'd3, 8'h81, 1'b0, 32'h02040800, 4'b1000, 8'h08, 1'b0, 1'b0);
        do_req("ror", 1'b1, 2'b10, 3'd1, 8'h01, 1'b0, 32'h80000000, 4'b1000, 8'h80, 1'b1, 1'b0);
        chk("ror/lcin_issue", first_lcin, 1);
        do_req("rcl", 1'b0, 2'b01, 3'd2, 8'h80, 1'b0, 32'h00010000, 4'b1000, 8'h01, 1'b0, 1'b0);
        do_req("asr", 1'b1, 2'b11, 3'd4, 8'h90, 1'b0, 32'hC8E4F2F9, 4'b0000, 8'hF9, 1'b0, 1'b0);
        chk("asr/lcin_issue", first_lcin, 1);
        do_req("cnt0", 1'b0, 2'b00, 3'd0, 8'h5A, 1'b1, 32'h0, 4'b0000, 8'h5A, 1'b1, 1'b0);
        do_req("poke", 1'b0, 2'b00, 3'd3, 8'h81, 1'b0, 32'h02040800, 4'b1000, 8'h08, 1'b0, 1'b1);

        // Abort in CAPTURE: no Done, everything back to zero.
        bus.dir = 1'b0; bus.mode = 2'b00; bus.count = 3'd3; bus.operand = 8'h81;
        bus.carry_in = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("abort/in_capture", {bus.busy, bus.ac5_lhs1, bus.ac4_lhs0}, 3'b100);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_zero("abort");
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.done) pulses++;
        end
        chk("abort/no_done", pulses, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
